div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 177 +++++++++++++++++
 tb/tb_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- 32-bit iterative integer divider (DIV / DIVU / REM / REMU).
//
// Signed operations are reduced to magnitudes, divided by an unsigned restoring
// shift-subtract core (one quotient bit per cycle, MSB first, 32 cycles) and the
// signs are restored when the last bit is produced.
//
// Optional feature macro: DIV_FAST_PATH_EN
//   When defined, divide-by-zero and signed overflow (0x80000000 / -1) requests
//   skip the iteration and go straight from IDLE to DONE (result one cycle
//   after the start edge). When undefined, every request takes the full
//   33-cycle path; the special-case results are identical in both builds.
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [1:0]  i_div_op,
    input  logic        i_start,
    output logic [31:0] o_div_data,
    output logic        o_busy,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude of a value when it is treated as signed.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Result of a division by zero: all ones for a quotient, dividend for a remainder.
    function automatic logic [31:0] zero_div_result(input logic is_rem, input logic [31:0] dividend);
        return is_rem ? dividend : 32'hFFFF_FFFF;
    endfunction

    // Conditional two's-complement negation used for sign restoration.
    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic negate);
        return negate ? (32'd0 - v) : v;
    endfunction

    // ---------------------------------------------------------------- state
    state_t      state_r;
    logic [4:0]  count_r;      // iteration counter, 0..31
    logic [31:0] opa_r;        // raw dividend, returned by REM/REMU on divide-by-zero
    logic [31:0] divisor_r;    // divisor magnitude
    logic [32:0] rem_r;        // partial remainder
    logic [31:0] quot_r;       // dividend magnitude shifting out, quotient bits shifting in
    logic        is_rem_r;     // request wants the remainder
    logic        neg_quot_r;   // quotient must be negated at the end
    logic        neg_rem_r;    // remainder must be negated at the end
    logic        div_zero_r;   // divisor was zero
    logic [31:0] result_r;
    logic        valid_r;

    // ------------------------------------------------------ request decode
    logic        in_signed_s;
    logic        in_div_zero_s;
    logic        fast_hit_s;
    logic [31:0] fast_result_s;

    assign in_signed_s   = ~i_div_op[0];
    assign in_div_zero_s = (i_op_b == 32'd0);

`ifdef DIV_FAST_PATH_EN
    logic in_overflow_s;

    assign in_overflow_s = in_signed_s && (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
    assign fast_hit_s    = in_div_zero_s || in_overflow_s;
    assign fast_result_s = in_div_zero_s ? zero_div_result(i_div_op[1], i_op_a)
                                         : (i_div_op[1] ? 32'd0 : 32'h8000_0000);
`else
    assign fast_hit_s    = 1'b0;
    assign fast_result_s = 32'd0;
`endif

    // ------------------------------------------------- restoring iteration
    // The remainder stays below the divisor, so rem_r[32] is normally clear;
    // it is still folded into the compare so the step is correct for any
    // 34-bit shifted value.
    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        step_ge_s;
    logic [32:0] rem_next_s;
    logic [31:0] quot_next_s;
    logic [31:0] quot_final_s;
    logic [31:0] rem_final_s;
    logic [31:0] final_s;

    assign shifted_s   = {rem_r[31:0], quot_r[31]};
    assign diff_s      = shifted_s - {1'b0, divisor_r};
    assign step_ge_s   = rem_r[32] | (shifted_s >= {1'b0, divisor_r});
    assign rem_next_s  = step_ge_s ? diff_s : shifted_s;
    assign quot_next_s = {quot_r[30:0], step_ge_s};

    // Signed overflow (0x80000000 / -1) needs no special handling here:
    // magnitude 0x80000000 negated is 0x80000000 and the remainder is zero.
    assign quot_final_s = apply_sign(quot_next_s, neg_quot_r);
    assign rem_final_s  = apply_sign(rem_next_s[31:0], neg_rem_r);
    assign final_s      = div_zero_r ? zero_div_result(is_rem_r, opa_r)
                                     : (is_rem_r ? rem_final_s : quot_final_s);

    // Control FSM and datapath registers: capture in IDLE, iterate in CALC, publish in DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            count_r    <= 5'd0;
            opa_r      <= 32'd0;
            divisor_r  <= 32'd0;
            rem_r      <= 33'd0;
            quot_r     <= 32'd0;
            is_rem_r   <= 1'b0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            result_r   <= 32'd0;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (i_start) begin
                        count_r <= 5'd0;
                        if (fast_hit_s) begin
                            result_r <= fast_result_s;
                            valid_r  <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            opa_r      <= i_op_a;
                            divisor_r  <= magnitude(i_op_b, in_signed_s);
                            quot_r     <= magnitude(i_op_a, in_signed_s);
                            rem_r      <= 33'd0;
                            is_rem_r   <= i_div_op[1];
                            neg_quot_r <= in_signed_s && (i_op_a[31] ^ i_op_b[31]);
                            neg_rem_r  <= in_signed_s && i_op_a[31];
                            div_zero_r <= in_div_zero_s;
                            state_r    <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r   <= rem_next_s;
                    quot_r  <= quot_next_s;
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        result_r <= final_s;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        valid_r  <= 1'b0;
                        state_r  <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_div_data = result_r;
    assign o_valid    = valid_r;
    assign o_busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// Directed cases for the documented examples plus randomized requests checked
// against an arithmetic reference model. Honours DIV_FAST_PATH_EN for latency.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  div_op;
    logic        start;
    logic [31:0] div_data;
    logic        busy;
    logic        valid;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .i_div_op   (div_op),
        .i_start    (start),
        .o_div_data (div_data),
        .o_busy     (busy),
        .o_valid    (valid)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            OP_DIV:  begin sr = sa / sb; return sr; end
            OP_REM:  begin sr = sa % sb; return sr; end
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    // Issue one request and check result, latency, busy span, output stability
    // and the return to idle. inject_at > 0 pulses a foreign start in that cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input string tag);
        logic [31:0] exp;
        logic [31:0] prev;
        int          lat;
        int          busy_cnt;
        int          exp_lat;
        logic        stable;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        @(negedge clk);
        op_a   = a;
        op_b   = b;
        div_op = op;
        start  = 1'b1;
        prev   = div_data;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        div_op = 2'($urandom_range(0, 3));
        lat      = 1;
        busy_cnt = 0;
        stable   = 1'b1;
        while (lat <= 40) begin
            if (busy) busy_cnt++;
            if (valid) break;
            if (div_data !== prev) stable = 1'b0;
            if (lat == inject_at) begin
                start  = 1'b1;
                op_a   = $urandom;
                op_b   = $urandom | 32'd1;
                div_op = 2'($urandom_range(0, 3));
            end else begin
                start  = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check_eq({tag, " result"}, div_data, exp);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check_eq({tag, " hold_during_calc"}, {31'd0, stable}, 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, " valid_pulse_end"}, {31'd0, valid}, 32'd0);
        check_eq({tag, " idle_after_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " result_held"}, div_data, exp);
    endtask

    initial begin
        int          valid_seen;
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          inj;

        reset  = 1'b1;
        start  = 1'b0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        div_op = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset data", div_data, 32'd0);
        check_eq("reset valid", {31'd0, valid}, 32'd0);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Documented examples
        run_op(OP_DIV,  32'd100,        32'd7,          0, "div 100/7");
        run_op(OP_REM,  32'd100,        32'd7,          0, "rem 100/7");
        run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          0, "div -7/2");
        run_op(OP_REM,  32'hFFFF_FFF9,  32'd2,          0, "rem -7/2");
        run_op(OP_DIVU, 32'hFFFF_FFFF,  32'd2,          0, "divu max/2");
        run_op(OP_REMU, 32'hFFFF_FFFF,  32'd2,          0, "remu max/2");
        run_op(OP_DIV,  32'd5,          32'd0,          0, "div 5/0");
        run_op(OP_REMU, 32'd5,          32'd0,          0, "remu 5/0");
        run_op(OP_REM,  32'hFFFF_FFFB,  32'd0,          0, "rem -5/0");
        run_op(OP_DIVU, 32'd5,          32'd0,          0, "divu 5/0");
        run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  0, "div ovf");
        run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  0, "rem ovf");
        run_op(OP_DIV,  32'd7,          32'hFFFF_FFFE,  0, "div 7/-2");
        run_op(OP_REM,  32'd7,          32'hFFFF_FFFE,  0, "rem 7/-2");

        // Start during CALC is ignored
        run_op(OP_DIV,  32'd1000,       32'd7,          5, "ignored start");

        // Abort mid-CALC by reset; previous result (142) is nonzero
        @(negedge clk);
        op_a = 32'd1000; op_b = 32'd3; div_op = OP_DIVU; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        check_eq("abort data", div_data, 32'd0);
        check_eq("abort valid", {31'd0, valid}, 32'd0);
        valid_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) valid_seen++;
        end
        check_eq("abort no_valid", 32'(valid_seen), 32'd0);
        run_op(OP_DIVU, 32'd9, 32'd3, 0, "divu 9/3 after abort");

        // Reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op_a = 32'd50; op_b = 32'd5; div_op = OP_DIVU;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        check_eq("reset_vs_start busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("reset_vs_start idle", {31'd0, busy}, 32'd0);

        // Randomized requests, issued back to back
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            op  = 2'($urandom_range(0, 3));
            inj = 0;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: b = 32'($urandom_range(1, 255));
                4: b = 32'd0 - 32'($urandom_range(1, 255));
                5: a = 32'($urandom_range(0, 1000));
                6: inj = $urandom_range(2, 30);
                default: ;
            endcase
            run_op(op, a, b, inj, $sformatf("rand%0d op%0d", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
